// File: rtl/dec_entry.sv
// Decimal keypad entry: accumulates digit/sign/backspace keys into an 8-bit operand, echoes it to disp_decimal.
// Latency: key to display/err 1 cycle, enter to out_valid 1 cycle; out_valid holds until out_ready, keys ignored meanwhile.
module dec_entry #(
    parameter int MAX_DIGITS = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       non_signed,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_value,
    output logic [7:0] disp_value,
    output logic       disp_enable,
    output logic       disp_non_signed,
    output logic [1:0] digit_count,
    output logic       err
);
    typedef enum logic [1:0] {IDLE, ENTRY, PUSH, ERROR} state_t;

    localparam logic [3:0] K_SIGN  = 4'd10;
    localparam logic [3:0] K_CLEAR = 4'd11;
    localparam logic [3:0] K_ENTER = 4'd12;
    localparam logic [3:0] K_BKSP  = 4'd13;

    state_t      state_q, state_d;
    logic [3:0]  d2_q, d1_q, d0_q, d2_d, d1_d, d0_d;
    logic        neg_q, neg_d, mode_q, mode_d, err_q, err_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_value_q, out_value_d, disp_value_q, disp_value_d;
    logic [1:0]  cnt_q, cnt_d;

    logic [9:0]  mag, limit;
    logic [13:0] cand;
    logic [7:0]  mag8_d;
    logic        mode_eff, act;

    assign mag  = 10'd100 * {6'd0, d2_q} + 10'd10 * {6'd0, d1_q} + {6'd0, d0_q};
    assign cand = 14'd10 * {4'd0, mag} + {10'd0, key_code};
    // The mode used for range checks switches to the live input on the key that leaves IDLE.
    assign mode_eff = (state_q == IDLE) ? non_signed : mode_q;
    assign limit    = mode_eff ? 10'd255 : (neg_q ? 10'd128 : 10'd127);
    assign act      = key_valid && (state_q == ENTRY ||
                      key_code <= 4'd9 || key_code == K_SIGN || key_code == K_ENTER);

    always_comb begin
        state_d     = state_q;
        d2_d        = d2_q;
        d1_d        = d1_q;
        d0_d        = d0_q;
        neg_d       = neg_q;
        mode_d      = mode_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_value_d = out_value_q;
        case (state_q)
            IDLE, ENTRY: begin
                if (act) begin
                    if (state_q == IDLE) mode_d = non_signed;
                    state_d = ENTRY;
                    if (key_code <= 4'd9) begin
                        if (cand > {4'd0, limit} ||
                            (cnt_q == 2'(MAX_DIGITS) && key_code != 4'd0)) begin
                            state_d = ERROR;
                            err_d   = 1'b1;
                        end else begin
                            d2_d = d1_q;
                            d1_d = d0_q;
                            d0_d = key_code;
                            if (!(cnt_q == 2'd0 && key_code == 4'd0)) cnt_d = cnt_q + 2'd1;
                        end
                    end else begin
                        case (key_code)
                            K_SIGN: begin
                                if (!mode_eff) begin
                                    if (neg_q && mag == 10'd128) begin
                                        state_d = ERROR;
                                        err_d   = 1'b1;
                                    end else begin
                                        neg_d = ~neg_q;
                                    end
                                end
                            end
                            K_CLEAR: begin
                                {d2_d, d1_d, d0_d} = 12'd0;
                                neg_d   = 1'b0;
                                cnt_d   = 2'd0;
                                state_d = IDLE;
                            end
                            K_ENTER: begin
                                out_value_d = neg_q ? (8'd0 - mag[7:0]) : mag[7:0];
                                out_valid_d = 1'b1;
                                state_d     = PUSH;
                            end
                            K_BKSP: begin
                                d0_d = d1_q;
                                d1_d = d2_q;
                                d2_d = 4'd0;
                                if (cnt_q != 2'd0) cnt_d = cnt_q - 2'd1;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            PUSH: begin
                if (out_ready) begin
                    out_valid_d        = 1'b0;
                    {d2_d, d1_d, d0_d} = 12'd0;
                    neg_d              = 1'b0;
                    cnt_d              = 2'd0;
                    state_d            = IDLE;
                end
            end
            default: begin
                if (key_valid && key_code == K_CLEAR) begin
                    err_d              = 1'b0;
                    {d2_d, d1_d, d0_d} = 12'd0;
                    neg_d              = 1'b0;
                    cnt_d              = 2'd0;
                    state_d            = IDLE;
                end
            end
        endcase
        // Accepted digits never exceed 255, so the echo only needs the low byte.
        mag8_d       = 8'd100 * {4'd0, d2_d} + 8'd10 * {4'd0, d1_d} + {4'd0, d0_d};
        disp_value_d = neg_d ? (8'd0 - mag8_d) : mag8_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            d2_q         <= 4'd0;
            d1_q         <= 4'd0;
            d0_q         <= 4'd0;
            neg_q        <= 1'b0;
            mode_q       <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= 2'd0;
            out_valid_q  <= 1'b0;
            out_value_q  <= 8'd0;
            disp_value_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            d2_q         <= d2_d;
            d1_q         <= d1_d;
            d0_q         <= d0_d;
            neg_q        <= neg_d;
            mode_q       <= mode_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_value_q  <= out_value_d;
            disp_value_q <= disp_value_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign out_value       = out_value_q;
    assign disp_value      = disp_value_q;
    assign disp_enable     = (state_q != IDLE);
    assign disp_non_signed = mode_q;
    assign digit_count     = cnt_q;
    assign err             = err_q;
endmodule

// File: tb/tb_dec_entry.sv
// Directed bench for dec_entry: keys driven on falling edges, outputs checked on the following falling edge.
module tb_dec_entry;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic       non_signed = 1'b0;
    logic       out_ready = 1'b1;
    logic       out_valid;
    logic [7:0] out_value;
    logic [7:0] disp_value;
    logic       disp_enable;
    logic       disp_non_signed;
    logic [1:0] digit_count;
    logic       err;

    int checks = 0;
    int errors = 0;

    dec_entry #(.MAX_DIGITS(3)) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .non_signed(non_signed), .out_ready(out_ready), .out_valid(out_valid),
        .out_value(out_value), .disp_value(disp_value), .disp_enable(disp_enable),
        .disp_non_signed(disp_non_signed), .digit_count(digit_count), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ov"},  16'(out_valid), 16'h0);
        chk({tag, "_val"}, 16'(out_value), 16'h0);
        chk({tag, "_dv"},  16'(disp_value), 16'h0);
        chk({tag, "_den"}, 16'(disp_enable), 16'h0);
        chk({tag, "_dns"}, 16'(disp_non_signed), 16'h0);
        chk({tag, "_cnt"}, 16'(digit_count), 16'h0);
        chk({tag, "_err"}, 16'(err), 16'h0);
    endtask

    initial begin
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Enter in IDLE pushes zero
        press(4'd12);
        chk("idle_enter_ov", 16'(out_valid), 16'h1);
        chk("idle_enter_val", 16'(out_value), 16'h00);
        @(negedge clk);
        chk("idle_enter_drop", 16'(out_valid), 16'h0);

        // Signed 127
        press(4'd1);
        chk("s127_d1", 16'(disp_value), 16'h01);
        chk("s127_en", 16'(disp_enable), 16'h1);
        chk("s127_c1", 16'(digit_count), 16'h1);
        press(4'd2);
        chk("s127_d2", 16'(disp_value), 16'h0C);
        press(4'd7);
        chk("s127_d3", 16'(disp_value), 16'h7F);
        chk("s127_c3", 16'(digit_count), 16'h3);
        press(4'd12);
        chk("s127_ov", 16'(out_valid), 16'h1);
        chk("s127_val", 16'(out_value), 16'h7F);
        @(negedge clk);
        chk("s127_ov0", 16'(out_valid), 16'h0);
        chk("s127_idle", 16'(disp_enable), 16'h0);
        chk("s127_dv0", 16'(disp_value), 16'h00);

        // Signed -128, then 128 without sign overflows
        press(4'd10);
        chk("sm128_sign", 16'(disp_value), 16'h00);
        press(4'd1);
        chk("sm128_d1", 16'(disp_value), 16'hFF);
        press(4'd2);
        chk("sm128_d2", 16'(disp_value), 16'hF4);
        press(4'd8);
        chk("sm128_d3", 16'(disp_value), 16'h80);
        press(4'd12);
        chk("sm128_val", 16'(out_value), 16'h80);
        @(negedge clk);
        press(4'd1);
        press(4'd2);
        press(4'd8);
        chk("s128_err", 16'(err), 16'h1);
        chk("s128_dv", 16'(disp_value), 16'h0C);
        chk("s128_cnt", 16'(digit_count), 16'h2);
        press(4'd12);
        chk("err_enter_ign", 16'(out_valid), 16'h0);
        press(4'd11);
        chk("err_clr", 16'(err), 16'h0);
        chk("err_clr_idle", 16'(disp_enable), 16'h0);
        chk("err_clr_dv", 16'(disp_value), 16'h00);

        // Unsigned 255; mode stays latched after non_signed drops
        non_signed = 1'b1;
        press(4'd2);
        non_signed = 1'b0;
        chk("u255_dns", 16'(disp_non_signed), 16'h1);
        press(4'd5);
        press(4'd5);
        chk("u255_dv", 16'(disp_value), 16'hFF);
        chk("u255_err", 16'(err), 16'h0);
        press(4'd12);
        chk("u255_val", 16'(out_value), 16'hFF);
        @(negedge clk);
        non_signed = 1'b1;
        press(4'd2);
        press(4'd5);
        press(4'd6);
        chk("u256_err", 16'(err), 16'h1);
        chk("u256_dv", 16'(disp_value), 16'h19);
        press(4'd11);
        press(4'd5);
        press(4'd10);
        chk("u_sign_ign", 16'(disp_value), 16'h05);
        press(4'd11);
        non_signed = 1'b0;

        // Leading zeros, backspace and the ignored codes
        press(4'd0);
        chk("lz_c0a", 16'(digit_count), 16'h0);
        chk("lz_en", 16'(disp_enable), 16'h1);
        press(4'd0);
        chk("lz_c0b", 16'(digit_count), 16'h0);
        press(4'd4);
        chk("lz_c1", 16'(digit_count), 16'h1);
        press(4'd2);
        chk("lz_c2", 16'(digit_count), 16'h2);
        chk("lz_dv42", 16'(disp_value), 16'h2A);
        press(4'd14);
        chk("k14_dv", 16'(disp_value), 16'h2A);
        chk("k14_cnt", 16'(digit_count), 16'h2);
        press(4'd13);
        chk("bs_cnt", 16'(digit_count), 16'h1);
        chk("bs_dv", 16'(disp_value), 16'h04);
        press(4'd11);

        // Sign off -128 is an error and keeps the value negative
        press(4'd10);
        press(4'd1);
        press(4'd2);
        press(4'd8);
        press(4'd10);
        chk("tog128_err", 16'(err), 16'h1);
        chk("tog128_dv", 16'(disp_value), 16'h80);
        press(4'd11);

        // Handshake stall, keys ignored during PUSH
        out_ready = 1'b0;
        press(4'd3);
        press(4'd12);
        chk("hs_ov", 16'(out_valid), 16'h1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hs_hold_ov", 16'(out_valid), 16'h1);
            chk("hs_hold_val", 16'(out_value), 16'h03);
        end
        press(4'd9);
        chk("hs_key_val", 16'(out_value), 16'h03);
        chk("hs_key_dv", 16'(disp_value), 16'h03);
        @(negedge clk);
        out_ready = 1'b1;
        key_valid = 1'b1;
        key_code  = 4'd5;
        @(negedge clk);
        key_valid = 1'b0;
        chk("hs_drop", 16'(out_valid), 16'h0);
        chk("hs_drop_dv", 16'(disp_value), 16'h00);
        chk("hs_drop_en", 16'(disp_enable), 16'h0);

        // Asynchronous reset mid-entry
        press(4'd4);
        press(4'd5);
        chk("rst_pre_dv", 16'(disp_value), 16'h2D);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        press(4'd7);
        press(4'd12);
        chk("rst_post_ov", 16'(out_valid), 16'h1);
        chk("rst_post_val", 16'(out_value), 16'h07);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
